// File: rtl/bram_wght_stream.sv
// rtl/bram_wght_stream.sv - NUM_CH-bank weight BRAM streaming NUM_CH-wide beats over valid/ready.
// Optional per-bank even parity with sticky par_err when WGHT_PARITY_EN is defined.
module bram_wght_stream #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 32,
  parameter int DATA_W = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CH_W   = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          len,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]        out_idx,
  output logic [NUM_CH-1:0]        par_err,
  input  logic                     par_clr
);

`ifdef WGHT_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                    state, state_nx;
  logic [MEM_W-1:0]          mem [NUM_CH][DEPTH];
  logic [MEM_W-1:0]          rd_q [NUM_CH];
  logic [ADDR_W-1:0]         rd_idx;
  logic                      inflight;
  logic [ADDR_W-1:0]         rd_addr, issue_addr;
  logic [CNT_W-1:0]          issued, acc, len_q;
  logic                      issue, pop;
  logic [1:0]                count, occ;
  logic [NUM_CH*DATA_W-1:0]  slot_data [2];
  logic [ADDR_W-1:0]         slot_idx [2];
  logic [NUM_CH*DATA_W-1:0]  new_data;
  logic [MEM_W-1:0]          wr_word;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  assign out_valid = (count != 2'd0);
  assign out_data  = slot_data[0];
  assign out_idx   = slot_idx[0];
  assign pop       = out_valid & out_ready;
  assign occ       = count + {1'b0, inflight};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // A pop in the same cycle frees a slot, which keeps one beat per cycle at full rate.
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;
    issue_addr = rd_addr;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            issue      = 1'b1;
            issue_addr = base_addr;
            state_nx   = S_STREAM;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_STREAM: begin
        busy  = 1'b1;
        issue = (issued != len_q) && ((occ != 2'd2) || pop);
        if (pop && (acc == len_q - CNT_W'(1))) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr  <= '0;
      issued   <= '0;
      acc      <= '0;
      len_q    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == S_IDLE) begin
        if (start && len != '0) begin
          len_q   <= len;
          issued  <= CNT_W'(1);
          acc     <= '0;
          rd_addr <= next_addr(base_addr);
        end
      end else if (state == S_STREAM) begin
        if (issue) begin
          rd_addr <= next_addr(rd_addr);
          issued  <= issued + CNT_W'(1);
        end
        if (pop) acc <= acc + CNT_W'(1);
      end
    end
  end

`ifdef WGHT_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
`endif

  // Non-blocking read and write give read-first behaviour on same-address collisions.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_en && (wr_ch == CH_W'(k))) mem[k][wr_addr] <= wr_word;
    end
    if (issue) begin
      for (int k = 0; k < NUM_CH; k++) rd_q[k] <= mem[k][issue_addr];
      rd_idx <= issue_addr;
    end
  end

  always_comb begin
    new_data = '0;
    for (int k = 0; k < NUM_CH; k++) new_data[k*DATA_W +: DATA_W] = rd_q[k][DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= 2'd0;
      slot_data[0] <= '0;
      slot_data[1] <= '0;
      slot_idx[0]  <= '0;
      slot_idx[1]  <= '0;
    end else begin
      case ({inflight, pop})
        2'b11: begin
          if (count == 2'd1) begin
            slot_data[0] <= new_data;
            slot_idx[0]  <= rd_idx;
          end else begin
            slot_data[0] <= slot_data[1];
            slot_idx[0]  <= slot_idx[1];
            slot_data[1] <= new_data;
            slot_idx[1]  <= rd_idx;
          end
        end
        2'b10: begin
          if (count == 2'd0) begin
            slot_data[0] <= new_data;
            slot_idx[0]  <= rd_idx;
          end else begin
            slot_data[1] <= new_data;
            slot_idx[1]  <= rd_idx;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          slot_data[0] <= slot_data[1];
          slot_idx[0]  <= slot_idx[1];
          count        <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef WGHT_PARITY_EN
  logic [NUM_CH-1:0] par_bad;

  always_comb begin
    par_bad = '0;
    for (int k = 0; k < NUM_CH; k++) par_bad[k] = inflight & (^rd_q[k]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err <= '0;
    else      par_err <= (par_clr ? '0 : par_err) | par_bad;
  end
`else
  logic unused_par_clr;
  assign unused_par_clr = par_clr;
  assign par_err        = '0;
`endif

endmodule

// File: tb/tb_bram_wght_stream.sv
// tb/tb_bram_wght_stream.sv - table-driven scoreboard bench for bram_wght_stream.
// Parity checks compile only when WGHT_PARITY_EN is defined.
module tb_bram_wght_stream;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     wr_en = 1'b0;
  logic [CH_W-1:0]          wr_ch = '0;
  logic [ADDR_W-1:0]        wr_addr = '0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic                     start = 1'b0;
  logic [ADDR_W-1:0]        base_addr = '0;
  logic [ADDR_W:0]          len = '0;
  logic                     busy, done, out_valid;
  logic                     out_ready = 1'b0;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [ADDR_W-1:0]        out_idx;
  logic [NUM_CH-1:0]        par_err;
  logic                     par_clr = 1'b0;

  bram_wght_stream dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .base_addr(base_addr), .len(len), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .par_err(par_err), .par_clr(par_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int base;
    int len;
    int pct;
    int restart_cyc;
    int exp_beats;
    int exp_first;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0]        idx;
    logic [NUM_CH*DATA_W-1:0] data;
  } exp_t;

  int   n_vec = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [DATA_W-1:0] model_mem [NUM_CH][DEPTH];
  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t expect_beat(input int a);
    exp_t e;
    e.idx  = ADDR_W'(a);
    e.data = '0;
    for (int k = 0; k < NUM_CH; k++) e.data[k*DATA_W +: DATA_W] = model_mem[k][a];
    return e;
  endfunction

  task automatic pop_compare(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_unexpected_beat"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, "_idx"}, 64'(out_idx), 64'(e.idx));
      check({name, "_data"}, out_data, e.data);
    end
  endtask

  task automatic run_stream(input vec_t v, input string name);
    int nbeats = 0, first = -1, done_cyc = -1, done_cnt = 0;
    logic stalled = 1'b0, busy_seen = 1'b0;
    logic [NUM_CH*DATA_W-1:0] pd = '0;
    logic [ADDR_W-1:0] pi = '0;
    for (int i = 0; i < v.len; i++) sb.push_back(expect_beat((v.base + i) % DEPTH));
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_W'(v.base); len = (ADDR_W+1)'(v.len); out_ready = 1'b0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.restart_cyc != 0 && cyc == v.restart_cyc) begin
        start = 1'b1; base_addr = 5'd20; len = 6'd10;
      end
      out_ready = ($urandom_range(0, 99) < v.pct);
      #1;
      if (busy) busy_seen = 1'b1;
      if (stalled) begin
        check({name, "_hold_valid"}, 64'(out_valid), 1);
        check({name, "_hold_data"}, out_data, pd);
        check({name, "_hold_idx"}, 64'(out_idx), 64'(pi));
      end
      if (out_valid && first < 0) first = cyc;
      if (out_valid && out_ready) begin
        if (v.base == 0 && v.len == 32 && nbeats == 5)
          check({name, "_beat5_lane2"}, 64'(out_data[2*DATA_W +: DATA_W]), 64'h0205);
        pop_compare(name);
        nbeats++;
      end
      stalled = out_valid && !out_ready;
      pd = out_data; pi = out_idx;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        check({name, "_busy_at_done"}, 64'(busy), 0);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    out_ready = 1'b0;
    check({name, "_done_seen"}, 64'(done_cyc >= 0), 1);
    check({name, "_beats"}, 64'(nbeats), 64'(v.exp_beats));
    check({name, "_done_count"}, 64'(done_cnt), 1);
    check({name, "_busy_seen"}, 64'(busy_seen), 64'(v.len > 0));
    check({name, "_sb_empty"}, 64'(sb.size()), 0);
    if (v.exp_first >= 0) begin
      check({name, "_first_lat"}, 64'(first), 64'(v.exp_first));
      check({name, "_done_cyc"}, 64'(done_cyc), 64'(v.len + 2));
    end
    if (v.len == 0) begin
      check({name, "_no_valid"}, 64'(first), 64'hFFFF_FFFF_FFFF_FFFF);
      check({name, "_done_cyc"}, 64'(done_cyc), 1);
    end
    sb.delete();
  endtask

  task automatic write_word(input int k, input int a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_ch = CH_W'(k); wr_addr = ADDR_W'(a); wr_data = d;
    model_mem[k][a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    tbl[0] = '{0, 32, 100, 0, 32, 2};
    tbl[1] = '{30, 4, 100, 0, 4, 2};
    tbl[2] = '{5, 20, 30, 0, 20, -1};
    tbl[3] = '{10, 0, 100, 0, 0, -1};
    tbl[4] = '{8, 6, 100, 3, 6, 2};
    tbl[5] = '{31, 1, 100, 0, 1, 2};
    tbl[6] = '{16, 32, 50, 0, 32, -1};

    @(negedge clk); #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_idx", 64'(out_idx), 0);
    check("rst_par", 64'(par_err), 0);
    rst = 1'b1;

    for (int k = 0; k < NUM_CH; k++)
      for (int i = 0; i < DEPTH; i++) write_word(k, i, DATA_W'(k * 256 + i));
    @(negedge clk); wr_en = 1'b0;

    for (int t = 0; t < 7; t++) run_stream(tbl[t], $sformatf("vec%0d", t));

    // Reset mid-stream
    for (int i = 0; i < 32; i++) sb.push_back(expect_beat(i));
    @(negedge clk);
    start = 1'b1; base_addr = '0; len = 6'd32;
    nb = 0;
    for (int cyc = 0; cyc < 50 && nb < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        pop_compare("mid");
        nb++;
      end
    end
    check("mid_three_beats", 64'(nb), 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 0);
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_data", out_data, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check("mid_rst_no_done", 64'(done), 0);
    end
    rst = 1'b1;
    sb.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("post_rst_idle_done", 64'({done, out_valid}), 0);
    end
    run_stream('{3, 5, 100, 0, 5, 2}, "fresh");

`ifdef WGHT_PARITY_EN
    @(negedge clk);
    dut.mem[1][7][0] = ~dut.mem[1][7][0];
    model_mem[1][7][0] = ~model_mem[1][7][0];
    run_stream('{4, 6, 100, 0, 6, 2}, "par");
    check("par_set", 64'(par_err), 64'(4'b0010));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("par_held", 64'(par_err), 64'(4'b0010));
    end
    @(negedge clk); par_clr = 1'b1;
    @(negedge clk); par_clr = 1'b0; #1;
    check("par_clr", 64'(par_err), 0);
`else
    check("par_tied", 64'(par_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
